// File: rtl/dpd_lut_loader.sv
// dpd_lut_loader: config-port initiator for the DPD actuator LUT bank.
// Streams a coefficient table into one selected LUT (write mode) or reads the
// LUT back and compares every word against the stream (verify mode).
//
// Handshake: a stream beat transfers on every rising clk edge where s_valid and
// s_ready are both high. s_ready depends only on internal state, never on
// s_valid, so the source may hold or drop s_valid freely between beats.
//
// lut_sel carries one bit more than a LUT index needs, so an out-of-range
// select (>= LUT_NUM) can be seen and rejected with err.
module dpd_lut_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int LUT_NUM    = 64,
    parameter int RD_LATENCY = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      mode,
    input  logic [$clog2(LUT_NUM):0]  lut_sel,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [ADDR_WIDTH:0]       err_count,
    output logic [ADDR_WIDTH-1:0]     err_addr,
    output logic [ADDR_WIDTH-1:0]     config_addr,
    output logic [DATA_WIDTH-1:0]     config_din,
    input  logic [DATA_WIDTH-1:0]     config_dout,
    output logic [LUT_NUM-1:0]        config_lutId,
    output logic                      config_web,
    output logic [1:0]                dbg_state
);

    localparam int SEL_W = $clog2(LUT_NUM) + 1;
    localparam int DRN_W = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_XFER  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wcnt_q, wcnt_d;
    logic                   last_q, last_d;     // final word accepted, no more beats
    logic                   mode_q, mode_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic [DRN_W-1:0]       drain_q, drain_d;

    logic                   web_q;
    logic [ADDR_WIDTH-1:0]  addr_q;
    logic [DATA_WIDTH-1:0]  din_q;

    // Expected-word pipe: stage 0 lines up with the address cycle, the last
    // stage with the cycle in which config_dout carries that address's word.
    logic                   pipe_vld_q  [0:RD_LATENCY];
    logic [DATA_WIDTH-1:0]  pipe_data_q [0:RD_LATENCY];
    logic [ADDR_WIDTH-1:0]  pipe_addr_q [0:RD_LATENCY];

    logic                   err_q;
    logic [ADDR_WIDTH:0]    err_cnt_q;
    logic [ADDR_WIDTH-1:0]  err_addr_q;

    logic accept, bad_sel, beat, last_beat, mismatch;

    assign accept    = (state_q == S_IDLE) && start;
    assign bad_sel   = lut_sel >= SEL_W'(LUT_NUM);
    assign s_ready   = (state_q == S_XFER) && !last_q;
    assign beat      = s_valid && s_ready;
    assign last_beat = beat && (&wcnt_q);
    assign mismatch  = pipe_vld_q[RD_LATENCY] && (config_dout != pipe_data_q[RD_LATENCY]);

    assign busy         = (state_q != S_IDLE);
    assign done         = (state_q == S_DONE);
    assign config_lutId = ((state_q == S_XFER) || (state_q == S_DRAIN))
                          ? ({{(LUT_NUM-1){1'b0}}, 1'b1} << sel_q) : '0;
    assign config_web   = web_q;
    assign config_addr  = addr_q;
    assign config_din   = din_q;
    assign err          = err_q;
    assign err_count    = err_cnt_q;
    assign err_addr     = err_addr_q;
    assign dbg_state    = state_q;

    // Next-state logic: operation sequencing, word counter and drain timer.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        last_d  = last_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    sel_d   = lut_sel;
                    mode_d  = mode;
                    wcnt_d  = '0;
                    last_d  = 1'b0;
                    drain_d = '0;
                    state_d = bad_sel ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (beat) begin
                    if (last_beat) last_d = 1'b1;
                    else           wcnt_d = wcnt_q + 1'b1;
                end
                // One cycle after the last beat its strobe/address is on the port.
                if (last_q) state_d = mode_q ? S_DRAIN : S_DONE;
            end
            S_DRAIN: begin
                if (drain_q == DRN_W'(RD_LATENCY - 1)) state_d = S_DONE;
                else                                   drain_d = drain_q + 1'b1;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            last_q  <= 1'b0;
            mode_q  <= 1'b0;
            sel_q   <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            last_q  <= last_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            drain_q <= drain_d;
        end
    end

    // Config port: one registered access per beat, strobe only on write beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            web_q  <= 1'b0;
            addr_q <= '0;
            din_q  <= '0;
        end else begin
            web_q <= beat && !mode_q;
            if (beat) begin
                addr_q <= wcnt_q;
                if (!mode_q) din_q <= s_data;
            end
        end
    end

    // Expected-word pipe for verify readback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i <= RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= '0;
                pipe_addr_q[i] <= '0;
            end
        end else begin
            pipe_vld_q[0]  <= beat && mode_q;
            pipe_data_q[0] <= s_data;
            pipe_addr_q[0] <= wcnt_q;
            for (int i = 1; i <= RD_LATENCY; i++) begin
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
                pipe_addr_q[i] <= pipe_addr_q[i-1];
            end
        end
    end

    // Error status: cleared by each accepted start, sticky otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q      <= 1'b0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (accept) begin
            err_q      <= bad_sel;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (mismatch) begin
            err_q <= 1'b1;
            if (!(&err_cnt_q)) err_cnt_q <= err_cnt_q + 1'b1;
            if (err_cnt_q == '0) err_addr_q <= pipe_addr_q[RD_LATENCY];
        end
    end

endmodule

// File: tb/tb_dpd_lut_loader.sv
// Bench for dpd_lut_loader: LUT bank model with RD_LATENCY readback, a
// transaction-level expectation model, a per-cycle compare process, and
// directed operations with literal pins.
module tb_dpd_lut_loader;

    localparam int DW = 32;
    localparam int AW = 9;
    localparam int NL = 64;
    localparam int RL = 2;
    localparam int DEPTH = 512;
    localparam int SW = 7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start = 1'b0;
    logic           mode = 1'b0;
    logic [SW-1:0]  lut_sel = '0;
    logic [DW-1:0]  s_data = '0;
    logic           s_valid = 1'b0;
    logic           s_ready, busy, done, err, config_web;
    logic [AW:0]    err_count;
    logic [AW-1:0]  err_addr, config_addr;
    logic [DW-1:0]  config_din, config_dout;
    logic [NL-1:0]  config_lutId;
    logic [1:0]     dbg_state;

    dpd_lut_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LUT_NUM(NL), .RD_LATENCY(RL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .lut_sel(lut_sel),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready), .busy(busy), .done(done),
        .err(err), .err_count(err_count), .err_addr(err_addr), .config_addr(config_addr),
        .config_din(config_din), .config_dout(config_dout), .config_lutId(config_lutId),
        .config_web(config_web), .dbg_state(dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- LUT bank model ----------------
    logic [DW-1:0] lut_mem [NL][DEPTH];
    logic [DW-1:0] rd_pipe [RL];
    logic [DW-1:0] rd_word;

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NL; i++)
            if (config_lutId[i]) rd_word = rd_word | lut_mem[i][config_addr];
    end

    always @(posedge clk) begin
        if (config_web)
            for (int i = 0; i < NL; i++)
                if (config_lutId[i]) lut_mem[i][config_addr] <= config_din;
        rd_pipe[0] <= rd_word;
        for (int j = 1; j < RL; j++) rd_pipe[j] <= rd_pipe[j-1];
    end
    assign config_dout = rd_pipe[RL-1];

    // ---------------- monitors ----------------
    int cyc = 0;
    int done_cyc = 0;
    int web_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (done) done_cyc = cyc;
    always @(negedge clk) if (config_web) web_cnt++;

    // ---------------- expectation model ----------------
    // Operation level: a valid start opens a window of DEPTH beats; each write
    // beat yields one strobe next cycle; done follows the last beat by 1 cycle
    // (write) or 1+RL cycles (verify); a bad select is done immediately.
    logic [AW+DW-1:0] exp_q[$];
    bit m_busy, m_mode, e_web, e_done, e_vbeat, e_err;
    int m_sel, m_beats, m_tail, e_addr, e_cnt, e_eaddr;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 0; m_mode = 0; m_sel = 0; m_beats = 0; m_tail = 0;
            e_web = 0; e_done = 0; e_vbeat = 0; e_addr = 0;
            e_err = 0; e_cnt = 0; e_eaddr = 0;
            exp_q.delete();
        end else begin
            bit was_done;
            was_done = e_done;
            e_web = 0; e_done = 0; e_vbeat = 0;
            if (was_done) begin
                m_busy = 0;
            end else if (!m_busy) begin
                if (start) begin
                    e_err = 0; e_cnt = 0; e_eaddr = 0;
                    m_sel = int'(lut_sel); m_mode = mode; m_beats = 0; m_busy = 1;
                    if (m_sel >= NL) begin
                        e_err = 1; e_done = 1;
                    end
                end
            end else if (m_beats < DEPTH) begin
                if (s_valid) begin
                    e_addr = m_beats;
                    if (!m_mode) begin
                        e_web = 1;
                        exp_q.push_back({AW'(m_beats), s_data});
                    end else begin
                        e_vbeat = 1;
                        if (s_data !== lut_mem[m_sel][m_beats]) begin
                            if (e_cnt == 0) e_eaddr = m_beats;
                            if (e_cnt < (1 << (AW + 1)) - 1) e_cnt++;
                            e_err = 1;
                        end
                    end
                    m_beats++;
                    if (m_beats == DEPTH) m_tail = m_mode ? 1 + RL : 1;
                end
            end else begin
                m_tail--;
                if (m_tail == 0) e_done = 1;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (rst_n) begin
            logic [63:0] e_lut;
            logic [AW+DW-1:0] e;
            e_lut = (m_busy && !e_done) ? (64'd1 << m_sel) : 64'd0;
            chk("s_ready", 64'(s_ready), 64'(m_busy && !e_done && m_beats < DEPTH));
            chk("busy", 64'(busy), 64'(m_busy));
            chk("done", 64'(done), 64'(e_done));
            chk("web", 64'(config_web), 64'(e_web));
            chk("lutId", config_lutId, e_lut);
            if (config_web) begin
                if (exp_q.size() == 0) chk("web_unexpected", 64'd1, 64'd0);
                else begin
                    e = exp_q.pop_front();
                    chk("wr_addr_din", 64'({config_addr, config_din}), 64'(e));
                end
            end
            if (e_vbeat) chk("rd_addr", 64'(config_addr), 64'(e_addr));
            if (e_done || !m_busy) begin
                chk("err", 64'(err), 64'(e_err));
                chk("err_count", 64'(err_count), 64'(e_cnt));
                chk("err_addr", 64'(err_addr), 64'(e_eaddr));
            end
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc = 0;

    task automatic do_start(input logic m, input logic [SW-1:0] sel);
        @(negedge clk);
        mode = m; lut_sel = sel; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start_cyc = cyc;
    endtask

    // Entered at a negedge; leaves at the negedge after the last accepted beat.
    task automatic stream(input int nwords, input bit gaps, input logic [DW-1:0] xorv,
                          input int bad_idx, input int poke_at);
        int k = 0;
        int c = 0;
        bit hs;
        while (k < nwords && c < 4 * DEPTH) begin
            s_valid = gaps ? (c % 2 == 0) : 1'b1;
            s_data  = (k == bad_idx) ? 32'hDEAD_BEEF : (DW'(k) ^ xorv);
            if (k == poke_at) begin
                start = 1'b1; lut_sel = 7'd9; mode = 1'b1;
            end else begin
                start = 1'b0;
            end
            #1 hs = s_valid && s_ready;
            @(posedge clk);
            if (hs) k++;
            c++;
            @(negedge clk);
        end
        s_valid = 1'b0; start = 1'b0;
        if (k < nwords) chk("stream_timeout", 64'(k), 64'(nwords));
    endtask

    task automatic wait_done(input int max);
        int c = 0;
        while (!done && c < max) begin
            @(negedge clk);
            c++;
        end
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(s_ready), 64'd0);
        chk("rst_web", 64'(config_web), 64'd0);
        chk("rst_lutId", config_lutId, 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: write ramp to LUT 5
        web_cnt = 0;
        do_start(1'b0, 7'd5);
        chk("t1_lutId_lit", config_lutId, 64'h20);
        stream(DEPTH, 1'b0, '0, -1, -1);
        wait_done(20);
        chk("t1_latency", 64'(done_cyc - start_cyc + 1), 64'd514);
        chk("t1_web_cnt", 64'(web_cnt), 64'd512);
        chk("t1_mem0", 64'(lut_mem[5][0]), 64'd0);
        chk("t1_mem300", 64'(lut_mem[5][300]), 64'd300);
        chk("t1_mem511", 64'(lut_mem[5][511]), 64'd511);

        // 2: verify same ramp
        do_start(1'b1, 7'd5);
        stream(DEPTH, 1'b0, '0, -1, -1);
        wait_done(20);
        chk("t2_latency", 64'(done_cyc - start_cyc + 1), 64'd516);
        chk("t2_err_lit", 64'(err), 64'd0);
        chk("t2_cnt_lit", 64'(err_count), 64'd0);

        // 3: table written with word 100 corrupted, then verified against the ramp
        do_start(1'b0, 7'd5);
        stream(DEPTH, 1'b0, '0, 100, -1);
        wait_done(20);
        do_start(1'b1, 7'd5);
        stream(DEPTH, 1'b0, '0, -1, -1);
        wait_done(20);
        chk("t3_err_lit", 64'(err), 64'd1);
        chk("t3_cnt_lit", 64'(err_count), 64'd1);
        chk("t3_addr_lit", 64'(err_addr), 64'd100);

        // 4: gapped stream to LUT 7 with a start pulse mid-transfer
        web_cnt = 0;
        do_start(1'b0, 7'd7);
        chk("t4_err_clear", 64'(err), 64'd0);
        stream(DEPTH, 1'b1, '0, -1, 50);
        wait_done(20);
        chk("t4_web_cnt", 64'(web_cnt), 64'd512);
        chk("t4_mem256", 64'(lut_mem[7][256]), 64'd256);

        // 5: reset during write at address 200, then restart on LUT 0
        do_start(1'b0, 7'd3);
        stream(201, 1'b0, '0, -1, -1);
        chk("t5_web_before", 64'(config_web), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_web", 64'(config_web), 64'd0);
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_ready", 64'(s_ready), 64'd0);
        chk("t5_rst_lutId", config_lutId, 64'd0);
        chk("t5_rst_addr", 64'(config_addr), 64'd0);
        chk("t5_rst_din", 64'(config_din), 64'd0);
        chk("t5_partial", 64'(lut_mem[3][199]), 64'd199);
        @(negedge clk);
        rst_n = 1'b1;
        do_start(1'b0, 7'd0);
        chk("t5_lutId_lit", config_lutId, 64'h1);
        stream(DEPTH, 1'b0, 32'hA5A5_0000, -1, -1);
        wait_done(20);
        chk("t5_mem0", 64'(lut_mem[0][0]), 64'hA5A5_0000);
        chk("t5_mem511", 64'(lut_mem[0][511]), 64'hA5A5_01FF);

        // 6: out-of-range select
        web_cnt = 0;
        do_start(1'b0, 7'd64);
        chk("t6_done_lit", 64'(done), 64'd1);
        chk("t6_err_lit", 64'(err), 64'd1);
        chk("t6_ready_lit", 64'(s_ready), 64'd0);
        chk("t6_lutId_lit", config_lutId, 64'd0);
        @(negedge clk);
        chk("t6_busy_after", 64'(busy), 64'd0);
        chk("t6_no_web", 64'(web_cnt), 64'd0);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
